// File: rtl/spd_mode_ctrl_pkg.sv
// Shared types and defaults for the speed-mode controller.
// Speed state codes double as the {A,B} code driven to the 7-segment decoder.
package spd_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_SLOW = 2'b01,
    ST_FAST = 2'b10
  } spd_state_e;

  localparam int DEF_SLOW_DUTY = 96;
  localparam int DEF_FAST_DUTY = 224;

endpackage

// File: rtl/spd_mode_ctrl_if.sv
// Board-side signal bundle of the speed-mode controller.
// The master drives buttons and the obstacle sensor; the slave (controller) drives the code, PWM and hold.
interface spd_mode_ctrl_if;

  logic btn_up;
  logic btn_dn;
  logic obstacle;
  logic spd_a;
  logic spd_b;
  logic motor_pwm;
  logic hold;

  modport master (
    output btn_up, btn_dn, obstacle,
    input  spd_a, spd_b, motor_pwm, hold
  );

  modport slave (
    input  btn_up, btn_dn, obstacle,
    output spd_a, spd_b, motor_pwm, hold
  );

endinterface

// File: rtl/spd_mode_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, DEB_CYCLES debounce, registered 1-cycle pulse on accepted press.
// Release is accepted as a level change but produces no pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d, level_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter tracks consecutive samples that disagree with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/spd_mode_ctrl.sv
// Speed-mode controller: debounced up/down buttons and obstacle sensor select STOP/SLOW/FAST,
// drive the {A,B} display code and a glitch-free motor PWM. Optional macro: IDLE_TIMEOUT_EN.
module spd_mode_ctrl
  import spd_pkg::*;
#(
  parameter int DEB_CYCLES  = 50000,
  parameter int HOLD_CYCLES = 1000,
  parameter int PWM_W       = 8,
  parameter int SLOW_DUTY   = DEF_SLOW_DUTY,
  parameter int FAST_DUTY   = DEF_FAST_DUTY,
  parameter int IDLE_CYCLES = 10000000
) (
  input logic            clk,
  input logic            rst_n,
  spd_mode_ctrl_if.slave io
);

  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int DW     = PWM_W + 1;
  // Duties at or above full scale saturate to 2^PWM_W so the compare is always true.
  localparam int SLOW_C = (SLOW_DUTY >= (2 ** PWM_W)) ? (2 ** PWM_W) : SLOW_DUTY;
  localparam int FAST_C = (FAST_DUTY >= (2 ** PWM_W)) ? (2 ** PWM_W) : FAST_DUTY;
  localparam logic [DW-1:0] SLOW_D = DW'(SLOW_C);
  localparam logic [DW-1:0] FAST_D = DW'(FAST_C);

  logic              up_p, dn_p;
  logic              obs_sync_q, obs_q;
  spd_state_e        state_q, state_d;
  logic              btn_chg;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_act;
  logic [PWM_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     duty_q, duty_d;
  logic              pwm_q, pwm_d;
  logic              up_ok, dn_ok;
  logic              idle_hit;

  function automatic logic [DW-1:0] target_duty(spd_state_e s);
    case (s)
      ST_SLOW: return SLOW_D;
      ST_FAST: return FAST_D;
      default: return '0;
    endcase
  endfunction

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (io.btn_up),
    .press_o (up_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (io.btn_dn),
    .press_o (dn_p)
  );

  assign hold_act = |hold_cnt_q;
  assign up_ok    = up_p & ~dn_p & ~hold_act & ~obs_q;
  assign dn_ok    = dn_p & ~up_p & ~hold_act & ~obs_q;

`ifdef IDLE_TIMEOUT_EN
  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  logic [IDLE_W-1:0] idle_q, idle_d;

  assign idle_hit = (state_q != ST_STOP) && !obs_q && !up_p && !dn_p &&
                    (idle_q == IDLE_W'(IDLE_CYCLES - 1));

  always_comb begin
    idle_d = idle_q + IDLE_W'(1);
    if (obs_q || up_p || dn_p || (state_q == ST_STOP) || (state_d != state_q)) begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign idle_hit = 1'b0;
`endif

  // Next state: obstacle wins, then idle timeout, then accepted button pulses.
  always_comb begin
    state_d = state_q;
    btn_chg = 1'b0;
    if (obs_q || idle_hit) begin
      state_d = ST_STOP;
    end else begin
      case (state_q)
        ST_STOP: if (up_ok) begin state_d = ST_SLOW; btn_chg = 1'b1; end
        ST_SLOW: begin
          if (up_ok) begin
            state_d = ST_FAST;
            btn_chg = 1'b1;
          end else if (dn_ok) begin
            state_d = ST_STOP;
            btn_chg = 1'b1;
          end
        end
        ST_FAST: if (dn_ok) begin state_d = ST_SLOW; btn_chg = 1'b1; end
        default: state_d = ST_STOP;
      endcase
    end
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (obs_q)         hold_cnt_d = '0;
    else if (btn_chg)  hold_cnt_d = HOLD_W'(HOLD_CYCLES);
    else if (hold_act) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
  end

  // New duty only takes effect at wrap, except STOP which cuts the motor at once.
  always_comb begin
    cnt_d  = cnt_q + PWM_W'(1);
    duty_d = duty_q;
    if (state_d == ST_STOP)  duty_d = '0;
    else if (&cnt_q)         duty_d = target_duty(state_d);
    pwm_d  = (state_d != ST_STOP) && ({1'b0, cnt_d} < duty_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_sync_q <= 1'b0;
      obs_q      <= 1'b0;
      state_q    <= ST_STOP;
      hold_cnt_q <= '0;
      cnt_q      <= '0;
      duty_q     <= '0;
      pwm_q      <= 1'b0;
    end else begin
      obs_sync_q <= io.obstacle;
      obs_q      <= obs_sync_q;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
    end
  end

  assign io.spd_a     = state_q[1];
  assign io.spd_b     = state_q[0];
  assign io.motor_pwm = pwm_q;
  assign io.hold      = hold_act;

endmodule
